// File: rtl/regfile_sweep.sv
// Register file with power-on clear sweep (NREGS cycles, SP_IDX preset to SP_INIT), ready once swept.
// Latency: combinational reads, writes visible the cycle after the edge; optional write-through via REGFILE_BYPASS_EN.
// Backpressure: none; writes during the sweep are dropped, reads return 0 until ready.
module regfile_sweep #(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter int          SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h000F_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic                     wr_en,
  input  logic [XLEN-1:0]          wr_data,
  output logic [XLEN-1:0]          rd1_data,
  output logic [XLEN-1:0]          rd2_data,
  output logic                     ready
);

  localparam int AW = $clog2(NREGS);
  localparam logic [XLEN-1:0] SP_VAL = XLEN'(SP_INIT);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      if (state == CLEAR)
        clr_idx <= clr_idx + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == AW'(NREGS - 1))
      state_nxt = RUN;
  end

  // The sweep owns the write port in CLEAR; core writes are simply not routed.
  always_comb begin
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_idx;
    mem_wdata = '0;
    if (state == CLEAR) begin
      mem_we    = (clr_idx != '0);
      mem_wdata = (clr_idx == AW'(SP_IDX)) ? SP_VAL : '0;
    end else begin
      ready     = 1'b1;
      mem_we    = wr_en && (rd_addr != '0);
      mem_waddr = rd_addr;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      regs[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    if (ready && rs1_addr != '0)
      rd1_data = regs[rs1_addr];
    if (ready && rs2_addr != '0)
      rd2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (ready && wr_en && rd_addr != '0) begin
      if (rs1_addr == rd_addr)
        rd1_data = wr_data;
      if (rs2_addr == rd_addr)
        rd2_data = wr_data;
    end
`endif
  end

endmodule

// File: doc/regfile_sweep.md
# regfile_sweep

Parametrised register file for the MiniRiscV core with a hardware clear sequencer, optional write-through bypass and configurable stack-pointer preset. It replaces the fixed 32×32 register array between decode (read ports) and writeback (write port). After reset it sweeps every entry to a defined value over NREGS cycles and flags `ready` once the core may issue.

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥ 4.
- `SP_IDX`, 2, index preset to `SP_INIT` by the clear sweep; must be nonzero and < NREGS.
- `SP_INIT`, 32'h000F_FFFF, stack-pointer preset value, truncated/zero-extended to XLEN.
- AW (localparam) = $clog2(NREGS).

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rs1_addr`  in  AW  read port 1 address.
- `rs2_addr`  in  AW  read port 2 address.
- `rd_addr`  in  AW  write address.
- `wr_en`  in  1  write strobe.
- `wr_data`  in  XLEN  write data.
- `rd1_data`  out  XLEN  read port 1 data, combinational.
- `rd2_data`  out  XLEN  read port 2 data, combinational.
- `ready`  out  1  high when sweep is complete and the file accepts reads/writes.

## Operation
- FSM states: CLEAR, RUN.
- `reset`=1 at an edge: state←CLEAR, clr_idx←0; no array write that edge. Held reset keeps CLEAR/idx 0.
- CLEAR (reset=0): each edge writes entry clr_idx with 0, except clr_idx==SP_IDX gets SP_INIT; clr_idx increments. The edge writing clr_idx==NREGS-1 moves state to RUN. Sweep takes exactly NREGS edges.
- CLEAR: `wr_en` ignored (write dropped, not queued); `rd1_data`/`rd2_data` forced to 0; `ready`=0.
- RUN: `ready`=1. Edge with `wr_en`=1 and `rd_addr`≠0 writes `wr_data` to `rd_addr`. `rd_addr`=0 writes are discarded.
- Reads: `rdN_data` = 0 when address is 0; otherwise stored entry (or bypassed value, see Configuration).
- Entry 0 is never written, including by the sweep (write of 0 is skipped or harmless; reads of 0 are forced regardless).
- Reset mid-sweep or mid-RUN: sweep restarts from idx 0; all prior contents are overwritten by the sweep.
- No X propagation: array has no reliance on `initial` blocks; defined contents come from the sweep only.

## Timing
- Reset outputs: `ready`=0, `rd1_data`=0, `rd2_data`=0.
- Reset released before edge E0: sweep writes at E0..E(NREGS-1); `ready` rises after E(NREGS-1), i.e. first RUN cycle is cycle NREGS after release.
- Write latency: value written at edge E is visible from the stored array in the cycle after E.
- Read latency: combinational, zero cycles, from address and state.
- Simultaneous read and write of same nonzero address in RUN: behaviour per `REGFILE_BYPASS_EN`.
- Both read ports may address the same register; both return the same value.

## Configuration
- `REGFILE_BYPASS_EN` defined: in RUN, if `wr_en`=1, `rd_addr`≠0 and `rsN_addr`==`rd_addr`, `rdN_data`=`wr_data` in the same cycle (write-through). Nothing is bypassed in CLEAR or for address 0.
- Not defined: reads always return the stored entry; a same-cycle write becomes visible the next cycle.

## Test plan
- Reset 1 cycle, release, NREGS=32 -> `ready`=0 for 32 cycles then 1; read x2 -> 32'h000F_FFFF, x1/x31 -> 0.
- RUN: write x5=32'hDEAD_BEEF, next cycle rs1=5, rs2=5 -> both ports 32'hDEAD_BEEF; write x0=32'h1234 -> x0 reads 0.
- Same-cycle write x7=32'hA5A5_A5A5 with rs1=7: with macro -> rd1 = A5A5_A5A5 that cycle; without -> old value that cycle, new value next cycle.
- `wr_en`=1 to x3=32'hFFFF_FFFF during sweep cycle 10 -> write dropped; after `ready`, x3 reads 0; reads during sweep return 0.
- Reset asserted at sweep cycle 15, then in RUN after x9=32'h55 -> `ready` drops next edge, full 32-cycle sweep restarts, x9 reads 0, x2 reads SP_INIT.
- Parameter sweep XLEN=16, NREGS=8, SP_IDX=3, SP_INIT=16'h0FF0 -> `ready` after 8 cycles, x3=16'h0FF0, others 0.
